// File: rtl/data_sram_slave_if.sv
// data_sram_slave_if: sram-like data port bundle
// master drives requests, slave returns addr_ok/data_ok/rdata
interface data_sram_slave_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_wstrb,
      output data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_wstrb,
      input  data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/data_sram_slave.sv
// data_sram_slave: data-side sram-like responder
// in-order completions after a fixed latency, word memory behind
module data_sram_slave #(
   parameter int ADDR_W   = 10,
   parameter int ADDR_LAT = 0,
   parameter int DATA_LAT = 1,
   parameter int QDEPTH   = 4
) (
   input logic              clk,
   input logic              resetn,
   data_sram_slave_if.slave bus
);
   localparam int          PW   = $clog2(QDEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(QDEPTH);
   localparam logic [2:0]  LOAD = 3'(DATA_LAT - 1);
   localparam logic [3:0]  ALAT = 4'(ADDR_LAT);

   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       q_data [QDEPTH];
   logic [2:0]        q_tmr [QDEPTH];
   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   logic [PW:0]       count;
   logic [2:0]        wait_cnt;
   logic [ADDR_W-1:0] idx;
   logic              accept;
   logic              pop;
   logic              unused_bits;

   assign idx = bus.data_sram_addr[ADDR_W+1:2];
   assign unused_bits = ^{bus.data_sram_addr[31:ADDR_W+2],
                          bus.data_sram_addr[1:0]};

   // wait_cnt + 1 > ADDR_LAT is wait_cnt >= ADDR_LAT without a 4-bit wrap
   assign accept = resetn && bus.data_sram_req
                   && (({1'b0, wait_cnt} + 4'd1) > ALAT)
                   && (count != FULL);
   assign pop = (count != '0) && (q_tmr[rp] == 3'd0);

   assign bus.data_sram_addr_ok = accept;
   assign bus.data_sram_data_ok = pop;
   assign bus.data_sram_rdata   = pop ? q_data[rp] : 32'd0;

   // byte-lane writes land on the acceptance edge
   always_ff @(posedge clk) begin
      if (accept && bus.data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_wstrb[i]) begin
               mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // entry timers count down; a push loads data and a fresh timer
   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++) begin
         if (q_tmr[i] != 3'd0) begin
            q_tmr[i] <= q_tmr[i] - 3'd1;
         end
      end
      if (accept) begin
         q_tmr[wp]  <= LOAD;
         q_data[wp] <= bus.data_sram_wr ? 32'd0 : mem[idx];
      end
   end

   // queue pointers, occupancy and request wait counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         wait_cnt <= 3'd0;
      end else begin
         if (accept) begin
            wp <= wp + PW'(1);
         end
         if (pop) begin
            rp <= rp + PW'(1);
         end
         case ({accept, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         if (!bus.data_sram_req || accept) begin
            wait_cnt <= 3'd0;
         end else if (wait_cnt != 3'd7) begin
            wait_cnt <= wait_cnt + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: scoreboard bench over three latency setups
// dut0 ALAT0/DLAT1, dut1 ALAT2/DLAT3, dut2 ALAT0/DLAT7/QDEPTH4
module tb_data_sram_slave;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   // cycle index, stable when sampled on the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   logic        req [3];
   logic        wr [3];
   logic [3:0]  strb [3];
   logic [31:0] addr [3];
   logic [31:0] wdata [3];
   logic        aok [3];
   logic        dok [3];
   logic [31:0] rd [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_sram_slave_if bus_if ();
      assign bus_if.data_sram_req   = req[g];
      assign bus_if.data_sram_wr    = wr[g];
      assign bus_if.data_sram_wstrb = strb[g];
      assign bus_if.data_sram_addr  = addr[g];
      assign bus_if.data_sram_wdata = wdata[g];
      assign aok[g] = bus_if.data_sram_addr_ok;
      assign dok[g] = bus_if.data_sram_data_ok;
      assign rd[g]  = bus_if.data_sram_rdata;
      data_sram_slave #(
         .ADDR_W  (10),
         .ADDR_LAT(g == 1 ? 2 : 0),
         .DATA_LAT(g == 0 ? 1 : (g == 1 ? 3 : 7)),
         .QDEPTH  (4)
      ) u_dut (
         .clk   (clk),
         .resetn(resetn),
         .bus   (bus_if)
      );
   end

   typedef struct {
      int          k;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb [$];

   function automatic int dlat(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
   endfunction

   // monitor: pop expected responses as data_ok appears
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (dok[k]) begin
            int hit;
            hit = -1;
            for (int i = 0; i < sb.size(); i++) begin
               if (hit < 0 && sb[i].k == k) hit = i;
            end
            total++;
            if (hit < 0) begin
               bad++;
               $display("FAIL spurious_data_ok dut%0d cyc=%0d rdata=%h",
                        k, cyc, rd[k]);
            end else begin
               if (rd[k] !== sb[hit].data || cyc != sb[hit].due) begin
                  bad++;
                  $display("FAIL resp dut%0d got rdata=%h cyc=%0d want rdata=%h cyc=%0d",
                           k, rd[k], cyc, sb[hit].data, sb[hit].due);
               end
               sb.delete(hit);
            end
         end else begin
            total++;
            if (rd[k] !== 32'd0) begin
               bad++;
               $display("FAIL idle_rdata dut%0d got %h want 0", k, rd[k]);
            end
         end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_resp dut%0d due=%0d now=%0d want rdata=%h",
                     sb[i].k, sb[i].due, cyc, sb[i].data);
            sb.delete(i);
         end
      end
   end

   task automatic issue(input int k, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input int exp_wait,
                        input string name);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      req[k]   = 1'b1;
      wr[k]    = w;
      strb[k]  = s;
      addr[k]  = a;
      wdata[k] = d;
      while (!done) begin
         @(negedge clk);
         if (aok[k]) begin
            sb.push_back('{k: k, data: exp, due: cyc + dlat(k)});
            done = 1'b1;
         end else begin
            n++;
            if (n > 40) begin
               total++;
               bad++;
               $display("FAIL %s accept_timeout dut%0d", name, k);
               done = 1'b1;
            end
         end
      end
      if (exp_wait >= 0) begin
         total++;
         if (n != exp_wait) begin
            bad++;
            $display("FAIL %s wait got %0d want %0d", name, n, exp_wait);
         end
      end
      @(posedge clk);
      #1;
      req[k] = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s drain got %0d pending want 0", name, sb.size());
      end
   endtask

   logic [31:0] rdv;

   initial begin
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; wr[k] = 1'b0; strb[k] = 4'h0;
         addr[k] = 32'd0; wdata[k] = 32'd0;
      end
      // reset held with a request pending on dut0
      req[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'hF;
      addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (aok[k] !== 1'b0) begin
               bad++;
               $display("FAIL rst_addr_ok dut%0d got %b want 0", k, aok[k]);
            end
         end
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;

      issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'd0, 0, "rst_first");
      issue(0, 1'b0, 4'hF, 32'h10, 32'd0, 32'hDEADBEEF, 0, "rd10");

      issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'd0, 0, "pre20");
      issue(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'd0, 0, "strb_wr");
      issue(0, 1'b0, 4'hF, 32'h20, 32'd0, 32'h11BB33DD, 0, "strb_rd");
      issue(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'd0, 0, "strb0_wr");
      issue(0, 1'b0, 4'hF, 32'h8000_1022, 32'd0, 32'h11BB33DD, 0, "alias_rd");
      issue(0, 1'b1, 4'hA, 32'h24, 32'h5566_7788, 32'd0, 0, "strb_a");
      issue(0, 1'b0, 4'hF, 32'h20, 32'd0, 32'h11BB33DD, 0, "nbr_rd");

      for (int i = 0; i < 4; i++) begin
         issue(0, 1'b1, 4'hF, 32'h200 + 32'(4*i), 32'h0BAD_0000 + 32'(i),
               32'd0, 0, "b2b_wr");
      end
      for (int i = 0; i < 4; i++) begin
         rdv = 32'h0BAD_0000 + 32'(i);
         issue(0, 1'b0, 4'hF, 32'h200 + 32'(4*i), 32'd0, rdv, 0, "b2b_rd");
      end
      drain("dut0");

      issue(1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'd0, 2, "lat_wr");
      issue(1, 1'b0, 4'hF, 32'h40, 32'd0, 32'hCAFEF00D, 2, "lat_rd");
      drain("dut1");

      for (int i = 0; i < 6; i++) begin
         issue(2, 1'b1, 4'hF, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i),
               32'd0, -1, "c_pre");
      end
      drain("dut2_pre");
      for (int i = 0; i < 6; i++) begin
         rdv = 32'hA000_0000 + 32'(i);
         issue(2, 1'b0, 4'hF, 32'h100 + 32'(4*i), 32'd0, rdv,
               (i == 4) ? 4 : 0, "full_rd");
      end
      drain("dut2_full");

      for (int i = 0; i < 3; i++) begin
         rdv = 32'hA000_0000 + 32'(i);
         issue(2, 1'b0, 4'hF, 32'h100 + 32'(4*i), 32'd0, rdv, 0, "mid_rd");
      end
      resetn = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].k == 2) sb.delete(i);
      end
      @(negedge clk);
      total++;
      if (aok[2] !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_addr_ok got %b want 0", aok[2]);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      issue(2, 1'b0, 4'hF, 32'h104, 32'd0, 32'hA000_0001, 0, "after_rst");
      drain("dut2_rst");
      repeat (10) @(posedge clk);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
